// File: rtl/register_file_mp.sv
// Multi-port register file: N combinational read ports, two write ports, optional
// same-cycle write->read bypass, hardwired zero register and a pending-write scoreboard.
module register_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   RA,
  output logic [NUM_READ*DATA_WIDTH-1:0]   RD,
  output logic [NUM_READ-1:0]              RBUSY,
  input  logic                             WE0,
  input  logic [ADDR_WIDTH-1:0]            WA0,
  input  logic [DATA_WIDTH-1:0]            WD0,
  input  logic                             WE1,
  input  logic [ADDR_WIDTH-1:0]            WA1,
  input  logic [DATA_WIDTH-1:0]            WD1,
  input  logic                             BSET,
  input  logic [ADDR_WIDTH-1:0]            BA,
  output logic [(2**ADDR_WIDTH)-1:0]       BUSY_VEC
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [Depth-1:0][DATA_WIDTH-1:0] r_mem;
  logic [Depth-1:0][DATA_WIDTH-1:0] w_mem_d;
  logic [Depth-1:0]                 r_busy;
  logic [Depth-1:0]                 w_busy_d;

  logic w_we0;
  logic w_we1;
  logic w_bset;

  // Accesses to register 0 are squashed up front so nothing downstream special-cases it.
  assign w_we0  = WE0  && !((ZERO_REG != 0) && (WA0 == '0));
  assign w_we1  = WE1  && !((ZERO_REG != 0) && (WA1 == '0));
  assign w_bset = BSET && !((ZERO_REG != 0) && (BA  == '0));

  always_comb begin
    w_mem_d  = r_mem;
    w_busy_d = r_busy;
    if (w_we0) begin
      w_mem_d[WA0]  = WD0;
      w_busy_d[WA0] = 1'b0;
    end
    if (w_we1) begin
      w_mem_d[WA1]  = WD1;
      w_busy_d[WA1] = 1'b0;
    end
    // A newly issued op supersedes a completing write to the same register.
    if (w_bset) begin
      w_busy_d[BA] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem  <= '0;
      r_busy <= '0;
    end else begin
      r_mem  <= w_mem_d;
      r_busy <= w_busy_d;
    end
  end

  assign BUSY_VEC = r_busy;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_zero;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_bhit;

    assign w_ra   = RA[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit0 = (BYPASS != 0) && w_we0 && (WA0 == w_ra);
    assign w_hit1 = (BYPASS != 0) && w_we1 && (WA1 == w_ra);
    assign w_bhit = w_bset && (BA == w_ra);

    assign RD[k*DATA_WIDTH +: DATA_WIDTH] = w_zero ? '0  :
                                            w_hit1 ? WD1 :
                                            w_hit0 ? WD0 : r_mem[w_ra];
    assign RBUSY[k] = w_zero                        ? 1'b0 :
                      ((w_hit0 || w_hit1) && !w_bhit) ? 1'b0 : r_busy[w_ra];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised bench for register_file_mp with default parameters, checked against an
// array-based model of the architectural register state and busy bits.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NREG = 32;

  logic             clk;
  logic             rst;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rbusy;
  logic             we0, we1, bset;
  logic [AW-1:0]    wa0, wa1, ba;
  logic [DW-1:0]    wd0, wd1;
  logic [NREG-1:0]  busy_vec;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [DW-1:0] m_mem [NREG];
  bit            m_busy [NREG];

  register_file_mp dut (
    .clk      (clk),
    .rst      (rst),
    .RA       (ra),
    .RD       (rd),
    .RBUSY    (rbusy),
    .WE0      (we0),
    .WA0      (wa0),
    .WD0      (wd0),
    .WE1      (we1),
    .WA1      (wa1),
    .WD1      (wd1),
    .BSET     (bset),
    .BA       (ba),
    .BUSY_VEC (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference read: architectural value an in-order pipeline would see this cycle.
  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input int a);
    bit wr_hit;
    if (a == 0) return 1'b0;
    wr_hit = (we0 && int'(wa0) == a) || (we1 && int'(wa1) == a);
    if (wr_hit && !(bset && int'(ba) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle_inputs();
    rst = 0; ra = '0; we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0; bset = 0; ba = '0;
  endtask

  // Settle combinational outputs and compare everything against the model.
  task automatic apply();
    logic [NREG-1:0] bv;
    #1;
    for (int k = 0; k < int'(NR); k++) begin
      int a;
      a = int'(ra[k*AW +: AW]);
      check_val($sformatf("rd%0d[a=%0d]", k, a), rd[k*DW +: DW], exp_rd(a));
      check_val($sformatf("rbusy%0d[a=%0d]", k, a), {31'b0, rbusy[k]}, {31'b0, exp_rbusy(a)});
    end
    for (int r = 0; r < int'(NREG); r++) bv[r] = m_busy[r];
    check_val("busy_vec", busy_vec, bv);
  endtask

  // Clock edge: advance the model by the rules for one cycle, return at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        m_mem[r] = '0;
        m_busy[r] = 0;
      end
    end else begin
      for (int r = 1; r < int'(NREG); r++) begin
        bit w0, w1;
        w0 = we0 && int'(wa0) == r;
        w1 = we1 && int'(wa1) == r;
        if (w1) m_mem[r] = wd1;
        else if (w0) m_mem[r] = wd0;
        if (bset && int'(ba) == r) m_busy[r] = 1;
        else if (w0 || w1) m_busy[r] = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(1, 0) == 1) return AW'($urandom_range(3, 0));
    return AW'($urandom_range(NREG - 1, 0));
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int r = 0; r < int'(NREG); r++) begin
      m_mem[r] = 'x;
      m_busy[r] = 0;
    end
    idle_inputs();
    @(negedge clk);

    // 1: reset, then read 5 and 9
    rst = 1;
    tick();
    idle_inputs();
    ra = {5'd5, 5'd9};
    apply();
    check_val("t1_rd0", rd[31:0], 32'h0);
    check_val("t1_rd1", rd[63:32], 32'h0);
    check_val("t1_busy_vec", busy_vec, 32'h0);
    tick();

    // 2: bypass then stored value
    idle_inputs();
    we0 = 1; wa0 = 10; wd0 = 32'h28082002; ra = {5'd0, 5'd10};
    apply();
    check_val("t2_bypass", rd[31:0], 32'h28082002);
    tick();
    idle_inputs();
    ra = {5'd0, 5'd10};
    apply();
    check_val("t2_stored", rd[31:0], 32'h28082002);
    tick();

    // 3: both ports write the same register, port 1 wins
    idle_inputs();
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA0000; we1 = 1; wa1 = 7; wd1 = 32'h5555FFFF;
    apply();
    tick();
    idle_inputs();
    ra = {5'd0, 5'd7};
    apply();
    check_val("t3_port1_wins", rd[31:0], 32'h5555FFFF);
    tick();

    // 4: register 0 ignores writes and BSET
    idle_inputs();
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; bset = 1; ba = 0; ra = {5'd0, 5'd0};
    apply();
    check_val("t4_zero_bypass", rd[31:0], 32'h0);
    tick();
    idle_inputs();
    apply();
    check_val("t4_zero_rd", rd[31:0], 32'h0);
    check_val("t4_zero_busy", {31'b0, busy_vec[0]}, 32'h0);
    tick();

    // 5: scoreboard set, observed, then cleared by a write
    idle_inputs();
    bset = 1; ba = 20;
    apply();
    tick();
    idle_inputs();
    ra = {5'd0, 5'd20};
    apply();
    check_val("t5_rbusy_set", {31'b0, rbusy[0]}, 32'h1);
    tick();
    idle_inputs();
    ra = {5'd0, 5'd20}; we1 = 1; wa1 = 20; wd1 = 32'h18022002;
    apply();
    check_val("t5_rbusy_wr", {31'b0, rbusy[0]}, 32'h0);
    check_val("t5_rd_wr", rd[31:0], 32'h18022002);
    tick();
    idle_inputs();
    apply();
    check_val("t5_busy_clr", {31'b0, busy_vec[20]}, 32'h0);
    tick();

    // 6: BSET beats same-cycle write; reset beats BSET
    idle_inputs();
    bset = 1; ba = 3; we0 = 1; wa0 = 3; wd0 = 32'h1; ra = {5'd0, 5'd3};
    apply();
    tick();
    idle_inputs();
    ra = {5'd0, 5'd3};
    apply();
    check_val("t6_reg3", rd[31:0], 32'h1);
    check_val("t6_busy3", {31'b0, busy_vec[3]}, 32'h1);
    tick();
    idle_inputs();
    rst = 1; bset = 1; ba = 4;
    tick();
    idle_inputs();
    ra = {5'd4, 5'd3};
    apply();
    check_val("t6_rst_busy", busy_vec, 32'h0);
    check_val("t6_rst_reg3", rd[31:0], 32'h0);
    tick();

    // Randomised traffic with collisions favoured and occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(63, 0) == 0);
      we0  = $urandom_range(1, 0) == 1;
      we1  = $urandom_range(1, 0) == 1;
      bset = $urandom_range(3, 0) == 0;
      wa0  = rnd_addr();
      wa1  = rnd_addr();
      ba   = rnd_addr();
      wd0  = $urandom;
      wd1  = $urandom;
      ra   = {rnd_addr(), rnd_addr()};
      apply();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
